// File: rtl/csr_counter_file.sv
// csr_counter_file: RV32 counter CSR unit (cycle/time/instret, NUM_HPM event
// counters, mcountinhibit, mcounteren, mscratch) with CSRRW/RS/RC execution,
// privilege and read-only checks, and a registered one-cycle response.
// Optional feature: define CSR_TIME_PRESCALE_EN to advance time once every
// TIME_DIV clocks instead of every clock.
module csr_counter_file #(
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int TIME_DIV   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            priv_mode,
  input  logic                  csr_valid,
  input  logic [1:0]            csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  input  logic                  csr_src_zero,
  input  logic                  instr_retired,
  input  logic [NUM_EVENTS-1:0] hpm_events,
  output logic                  csr_resp_valid,
  output logic [31:0]           csr_rdata,
  output logic                  csr_illegal
);

  localparam int EW = $clog2(NUM_EVENTS + 1);
  // counter-enable bits 0..2+NUM_HPM exist; inhibit additionally lacks bit 1 (time)
  localparam logic [31:0] EN_MASK  = (32'd1 << (3 + NUM_HPM)) - 32'd1;
  localparam logic [31:0] INH_MASK = EN_MASK & ~32'h2;

  logic [63:0]   cycle_q, time_q, instret_q;
  logic [63:0]   hpm_q   [NUM_HPM];
  logic [EW-1:0] event_q [NUM_HPM];
  logic [31:0]   inhibit_q, counteren_q, scratch_q;

  logic [1:0]         eff_priv;
  logic [4:0]         idx;
  logic               ctr_hi, is_ctr_u, is_ctr_m, ctr_exists, is_event, mapped;
  logic [63:0]        ctr_val;
  logic [31:0]        old_val, new_val;
  logic               does_write, illegal, commit, wr_ctr;
  logic [NUM_HPM-1:0] event_sel, hpm_inc;
  logic               time_tick;

  // lower half on write wins over the increment; the untouched half keeps its old value
  function automatic logic [63:0] ctr_next(input logic [63:0] cur, input logic inc,
                                           input logic wr_lo, input logic wr_hi,
                                           input logic [31:0] wv);
    if (wr_lo) return {cur[63:32], wv};
    if (wr_hi) return {wv, cur[31:0]};
    return cur + {63'd0, inc};
  endfunction

  assign eff_priv = (priv_mode == 2'b11) ? 2'b11 : 2'b00;
  assign idx      = csr_addr[4:0];
  assign ctr_hi   = csr_addr[7];

  // address decode and selection of the current (old) CSR value
  always_comb begin
    is_ctr_u   = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00);
    is_ctr_m   = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
    ctr_val    = 64'd0;
    ctr_exists = 1'b0;
    event_sel  = '0;
    old_val    = 32'd0;
    mapped     = 1'b1;
    case (idx)
      5'd0:    begin ctr_val = cycle_q;   ctr_exists = 1'b1;     end
      5'd1:    begin ctr_val = time_q;    ctr_exists = is_ctr_u; end
      5'd2:    begin ctr_val = instret_q; ctr_exists = 1'b1;     end
      default: ;
    endcase
    for (int i = 0; i < NUM_HPM; i++) begin
      if (idx == 5'(i + 3)) begin
        ctr_val    = hpm_q[i];
        ctr_exists = 1'b1;
      end
      event_sel[i] = (csr_addr[11:5] == 7'b0011001) && (idx == 5'(i + 3));
    end
    is_event = |event_sel;
    if ((is_ctr_u || is_ctr_m) && ctr_exists) begin
      old_val = ctr_hi ? ctr_val[63:32] : ctr_val[31:0];
    end else if (csr_addr == 12'h306) begin
      old_val = counteren_q;
    end else if (csr_addr == 12'h320) begin
      old_val = inhibit_q;
    end else if (is_event) begin
      for (int i = 0; i < NUM_HPM; i++) begin
        if (event_sel[i]) old_val = 32'(event_q[i]);
      end
    end else if (csr_addr == 12'h340) begin
      old_val = scratch_q;
    end else begin
      mapped = 1'b0;
    end
  end

  assign does_write = (csr_op == 2'b01) || !csr_src_zero;

  // exception conditions: unmapped, bad op, privilege, counter enable, read-only write
  always_comb begin
    illegal = 1'b0;
    if (!mapped) illegal = 1'b1;
    if (csr_op == 2'b00) illegal = 1'b1;
    if (eff_priv < csr_addr[9:8]) illegal = 1'b1;
    if (is_ctr_u && (eff_priv == 2'b00) && !counteren_q[idx]) illegal = 1'b1;
    if (does_write && (csr_addr[11:10] == 2'b11)) illegal = 1'b1;
  end

  // value to be written back for RW / RS / RC
  always_comb begin
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      default: new_val = old_val & ~csr_wdata;
    endcase
  end

  assign commit = csr_valid && !illegal && does_write;
  assign wr_ctr = commit && is_ctr_m && ctr_exists;

  // event counters count when their selector names a live strobe and they are not inhibited
  always_comb begin
    hpm_inc = '0;
    for (int i = 0; i < NUM_HPM; i++) begin
      for (int k = 0; k < NUM_EVENTS; k++) begin
        if ((event_q[i] == EW'(k + 1)) && hpm_events[k]) hpm_inc[i] = 1'b1;
      end
      if (inhibit_q[3 + i]) hpm_inc[i] = 1'b0;
    end
  end

`ifdef CSR_TIME_PRESCALE_EN
  localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  logic [PW-1:0] presc_q;
  assign time_tick = (presc_q == PW'(TIME_DIV - 1));

  // time prescaler wraps to zero on each tick
  always_ff @(posedge clock) begin
    if (reset || time_tick) presc_q <= '0;
    else                    presc_q <= presc_q + PW'(1);
  end
`else
  assign time_tick = 1'b1;
`endif

  // 64-bit counters: increment or half-word write
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q   <= 64'd0;
      time_q    <= 64'd0;
      instret_q <= 64'd0;
      for (int i = 0; i < NUM_HPM; i++) hpm_q[i] <= 64'd0;
    end else begin
      cycle_q   <= ctr_next(cycle_q, !inhibit_q[0], wr_ctr && (idx == 5'd0) && !ctr_hi,
                            wr_ctr && (idx == 5'd0) && ctr_hi, new_val);
      time_q    <= time_q + {63'd0, time_tick};
      instret_q <= ctr_next(instret_q, instr_retired && !inhibit_q[2],
                            wr_ctr && (idx == 5'd2) && !ctr_hi,
                            wr_ctr && (idx == 5'd2) && ctr_hi, new_val);
      for (int i = 0; i < NUM_HPM; i++) begin
        hpm_q[i] <= ctr_next(hpm_q[i], hpm_inc[i], wr_ctr && (idx == 5'(i + 3)) && !ctr_hi,
                             wr_ctr && (idx == 5'(i + 3)) && ctr_hi, new_val);
      end
    end
  end

  // control registers: counter enable, inhibit, event selectors, scratch
  always_ff @(posedge clock) begin
    if (reset) begin
      counteren_q <= 32'd0;
      inhibit_q   <= 32'd0;
      scratch_q   <= 32'd0;
      for (int i = 0; i < NUM_HPM; i++) event_q[i] <= '0;
    end else if (commit) begin
      if (csr_addr == 12'h306) counteren_q <= new_val & EN_MASK;
      if (csr_addr == 12'h320) inhibit_q   <= new_val & INH_MASK;
      if (csr_addr == 12'h340) scratch_q   <= new_val;
      for (int i = 0; i < NUM_HPM; i++) begin
        if (event_sel[i]) event_q[i] <= new_val[EW-1:0];
      end
    end
  end

  // registered response, one cycle after the request
  always_ff @(posedge clock) begin
    if (reset || !csr_valid) begin
      csr_resp_valid <= 1'b0;
      csr_rdata      <= 32'd0;
      csr_illegal    <= 1'b0;
    end else begin
      csr_resp_valid <= 1'b1;
      csr_rdata      <= illegal ? 32'd0 : old_val;
      csr_illegal    <= illegal;
    end
  end

endmodule
